// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble size, FSM states
// and the operand-width legality rule.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A width is legal when it splits into one or more whole nibbles.
    function automatic bit width_legal(input int unsigned w);
        return (w >= NIBBLE) && ((w % NIBBLE) == 0);
    endfunction

endpackage : nibble_serial_adder_pkg

// File: rtl/carry_skip_adder.sv
// 4-bit carry-skip adder: ripple carry inside the block, with a bypass of
// cin to carry_out when every bit position propagates.
module carry_skip_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [3:0] prop;
    logic [3:0] gen;
    logic [4:0] carry;

    assign prop = a ^ b;
    assign gen  = a & b;

    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum       = prop ^ carry[3:0];
    assign carry_out = (&prop) ? cin : carry[4];

endmodule : carry_skip_adder

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit carry-skip adder,
// processing one nibble per clock, LSB first, with a registered carry chain.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned N     = WIDTH / NIBBLE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
    end

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               c_r;

    logic [NIBBLE-1:0]  nib_a;
    logic [NIBBLE-1:0]  nib_b;
    logic [NIBBLE-1:0]  nib_sum;
    logic               nib_co;

    // Current nibble slice presented to the shared adder.
    assign nib_a = a_r[idx*NIBBLE +: NIBBLE];
    assign nib_b = b_r[idx*NIBBLE +: NIBBLE];

    carry_skip_adder u_csa (
        .a         (nib_a),
        .b         (nib_b),
        .cin       (c_r),
        .sum       (nib_sum),
        .carry_out (nib_co)
    );

    // Sequencer: accept in IDLE/DONE, one nibble per RUN cycle, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r       <= a;
                        b_r       <= b;
                        c_r       <= cin;
                        sum       <= '0;
                        carry_out <= 1'b0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[idx*NIBBLE +: NIBBLE] <= nib_sum;
                    c_r                       <= nib_co;
                    if (idx == LAST_IDX) begin
                        carry_out <= nib_co;
                        idx       <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = WIDTH / 4;
    localparam int          LIMIT = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic c);
        @(negedge clk);
        a     = aa;
        b     = bb;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~aa;
        b     = ~bb;
        cin   = ~c;
    endtask

    // Wait for done from the first negedge after acceptance (cycle 1).
    task automatic wait_done(input string tag, output int cyc, output int nbusy);
        cyc   = 1;
        nbusy = 0;
        while (!done && cyc < LIMIT) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                         input logic c, input logic [WIDTH-1:0] exp_sum, input logic exp_co);
        int cyc, nb;
        launch(aa, bb, c);
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        wait_done(tag, cyc, nb);
        check({tag, "_latency"}, 32'(cyc), 32'(N + 1));
        check({tag, "_busy_cycles"}, 32'(nb), 32'(N));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(carry_out), 32'(exp_co));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        int cyc, nb, k;
        bit seen;
        rst_n = 1'b0;
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        do_op("t1", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        do_op("t3a", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1);
        do_op("t3b", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Start re-asserted mid-run must be ignored.
        launch(16'h0001, 16'h0001, 1'b0);
        a = 16'hFFFF;
        b = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_latency", 32'(cyc), 32'(N + 1));
        check("t4_sum", 32'(sum), 32'h0002);
        check("t4_cout", 32'(carry_out), 32'd0);
        @(negedge clk);
        check("t4_single_done", 32'(done), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        a     = 16'h0F0F;
        b     = 16'h00F1;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        wait_done("t5a", cyc, nb);
        check("t5a_sum", 32'(sum), 32'h1000);
        check("t5a_cout", 32'(carry_out), 32'd0);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        check("t5_reaccept_busy", 32'(busy), 32'd1);
        check("t5_sum_cleared", 32'(sum), 32'd0);
        while (!done && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        check("t5_gap", 32'(k), 32'(N + 1));
        check("t5b_sum", 32'(sum), 32'h1000);
        check("t5b_cout", 32'(carry_out), 32'd0);

        // Asynchronous reset during RUN aborts with no done pulse.
        @(negedge clk);
        launch(16'h1234, 16'h4321, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_abort_busy", 32'(busy), 32'd0);
        check("t6_abort_done", 32'(done), 32'd0);
        check("t6_abort_sum", 32'(sum), 32'd0);
        check("t6_abort_cout", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("t6_no_done", 32'(seen), 32'd0);
        do_op("t6", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nibble_serial_adder
